pixel_packer: RTL
=================

// Module: pixel_packer
// PURPOSE
// - Sits directly downstream of the pixel buffer: consumes 24-bit RGB pixels (in_stream_ready/out_valid handshake).
// - Packs them into 32-bit AXI4-Stream words for the video DMA/VDMA: 4 pixels -> 3 words.
// - Converts per-pixel SOF/EOL into TUSER/TLAST.
// - Zero-pads a partial word at end of line.
// PARAMETERS
// - PAD_BYTE  8'h00  value written into unused byte lanes of an EOL-flushed word
// PORTS
// - aclk           in   1   single clock; all logic on posedge
// - aresetn        in   1   synchronous, active-HIGH reset (asserted = 1), despite the name
// - in_r/in_g/in_b in   8   pixel colour from pixel buffer
// - in_sof         in   1   pixel is first of frame
// - in_eol         in   1   pixel is last of line
// - in_valid       in   1   pixel present this cycle
// - in_ready       out  1   packer can accept a pixel (drives pixel buffer in_stream_ready)
// - m_axis_tdata   out  32  packed bytes, byte 0 in [7:0]
// - m_axis_tvalid  out  1   word valid
// - m_axis_tready  in   1   downstream accepts word
// - m_axis_tlast   out  1   word contains last byte of a line
// - m_axis_tuser   out  1   word contains first byte of a frame
// - err_sof_align  out  1   sticky: SOF arrived with leftover bytes pending
// BEHAVIOUR
// - Reset: tvalid=0, tdata=0, tlast=0, tuser=0, err_sof_align=0, leftover count L=0, state=RUN.
//   Reset mid-frame discards all pending bytes and the output word.
// - Accept when in_valid & in_ready.
//   - in_ready = (state==RUN) & (~m_axis_tvalid | m_axis_tready); never depends combinationally on in_valid.
// - Byte stream order per pixel: R, G, B. Leftover register holds L in {0,1,2,3} bytes.
// - Accepted pixel appends 3 bytes, giving L+3 bytes:
//   - L=0 -> no word, L'=3
//   - L=3 -> emit word, L'=2
//   - L=2 -> emit word, L'=1
//   - L=1 -> emit word, L'=0
// - Word layout, pixels p0..p3, 3 words:
//   - W0 = {p1.r, p0.b, p0.g, p0.r}
//   - W1 = {p2.g, p2.r, p1.b, p1.g}
//   - W2 = {p3.b, p3.g, p3.r, p2.b}
// - Latency: word is registered; tvalid rises the cycle after the completing pixel is accepted.
//   - Word held stable until tready. No combinational in->out path.
// - TUSER is 1 on the word containing the SOF pixel's R byte.
//   - If SOF is held in leftover (L'=3), the flag is held with it.
// - EOL handling:
//   - After appending, any remaining leftover bytes are flushed as one extra word: pad upper lanes with PAD_BYTE, TLAST=1, L'=0.
//   - If the EOL pixel itself emitted a full word and leftover is 0, that word carries TLAST=1.
// - States:
//   - RUN: normal packing.
//   - FLUSH: entered when an EOL pixel leaves leftover>0 AND also emitted a full word (L=3 or L=2 case).
//     - in_ready=0; the padded word is loaded when the output register frees.
//     - Returns to RUN once loaded.
//   - L=0 EOL (3 bytes) loads the padded word directly from RUN, with no FLUSH.
// - SOF with L!=0: pending bytes discarded, err_sof_align set (sticky until reset). The pixel is packed from L=0.
// - Backpressure: tready low holds tdata/tlast/tuser/tvalid and deasserts in_ready; no pixel is lost or duplicated.
// - Simultaneous output drain and new word load in the same cycle is allowed (full throughput, 1 word/cycle).
// STRUCTURE
// - pixel_packer_pkg:
//   - typedef rgb_t {r,g,b}
//   - enum pk_state_t {RUN, FLUSH}
//   - localparam WORD_W=32, BYTES_PER_PIX=3
// - One natural sub-module: axis_out_reg, a single-entry registered AXIS output slice with load/hold.
// - Packing datapath and leftover register live in pixel_packer.
// TESTING
// - Frame of 4 pixels (11,12,13)(21,22,23)(31,32,33)(41,42,43), SOF on p0, EOL on p3, tready=1:
//   - W0=0x15_0D_0C_0B, tuser=1
//   - W1=0x20_1F_17_16
//   - W2=0x2B_2A_29_21, tlast=1
// - Line of 2 pixels (01,02,03)(04,05,06), EOL on 2nd:
//   - words 0x04030201 then 0x00000605 (PAD 0), tlast only on 2nd
//   - in_ready low for exactly the FLUSH cycle
// - Line of 1 pixel (AA,BB,CC) with EOL: single word 0x00CCBBAA, tlast=1, tuser as driven.
// - tready held 0 for 5 cycles mid-line:
//   - in_ready=0 throughout, tdata stable
//   - after release, sequence matches the no-backpressure reference byte-for-byte
// - SOF on pixel with L=2: err_sof_align=1, next word starts with the SOF pixel's R byte, tuser=1.
// - aresetn=1 for one cycle with L=3 and a word pending:
//   - tvalid=0 next cycle
//   - following pixels pack from L=0, no stale bytes emitted

Source files
------------

// File: rtl/pixel_packer_pkg.sv
// Shared types and helpers for the 24-bit RGB to 32-bit AXI4-Stream packer.
package pixel_packer_pkg;

    localparam int WORD_W        = 32;
    localparam int BYTES_PER_PIX = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pk_state_t;

    // Builds an end-of-line word: the lowest n bytes come from 'bytes', the rest are pad.
    function automatic logic [WORD_W-1:0] pad_word(input logic [23:0] bytes,
                                                   input logic [1:0]  n,
                                                   input logic [7:0]  pad);
        logic [WORD_W-1:0] w;
        w = {4{pad}};
        for (int i = 0; i < BYTES_PER_PIX; i++) begin
            if (i < int'(n)) w[i*8 +: 8] = bytes[i*8 +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/pixel_packer_axis_out_reg.sv
// Single-entry registered AXI4-Stream output slice: loads a word, holds it until tready.
module pixel_packer_axis_out_reg #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         load_user,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         tlast,
    output logic         tuser
);

    // The caller only asserts load when the slot is empty or draining this cycle.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
            tuser  <= load_user;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs R,G,B byte triplets into 32-bit AXI4-Stream words (4 pixels -> 3 words),
// mapping SOF/EOL to TUSER/TLAST and padding a partial word at end of line.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [7:0]        in_r,
    input  logic [7:0]        in_g,
    input  logic [7:0]        in_b,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              err_sof_align,
    output pk_state_t         state_dbg
);

    // Handshake: a pixel transfers on a rising edge where in_valid & in_ready; a word
    // transfers where m_axis_tvalid & m_axis_tready. in_ready never looks at in_valid.

    pk_state_t         state_q, state_d;
    logic [7:0]        lo_q [3];
    logic [7:0]        lo_d [3];
    logic [1:0]        lo_cnt_q, lo_cnt_d;
    logic              lo_sof_q, lo_sof_d;
    logic              err_q, err_d;
    rgb_t              pix;
    logic              out_free;
    logic              accept;
    logic [1:0]        eff_cnt;
    logic [7:0]        cat [6];
    logic              load;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              load_user;

    assign pix      = '{r: in_r, g: in_g, b: in_b};
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign in_ready = (state_q == RUN) & out_free;
    assign accept   = in_valid & in_ready;
    // SOF always restarts packing on a word boundary, dropping any leftover.
    assign eff_cnt  = in_sof ? 2'd0 : lo_cnt_q;

    assign err_sof_align = err_q;
    assign state_dbg     = state_q;

    always_comb begin
        for (int i = 0; i < 6; i++) cat[i] = PAD_BYTE;
        case (eff_cnt)
            2'd0: begin
                cat[0] = pix.r; cat[1] = pix.g; cat[2] = pix.b;
            end
            2'd1: begin
                cat[0] = lo_q[0];
                cat[1] = pix.r; cat[2] = pix.g; cat[3] = pix.b;
            end
            2'd2: begin
                cat[0] = lo_q[0]; cat[1] = lo_q[1];
                cat[2] = pix.r; cat[3] = pix.g; cat[4] = pix.b;
            end
            default: begin
                cat[0] = lo_q[0]; cat[1] = lo_q[1]; cat[2] = lo_q[2];
                cat[3] = pix.r; cat[4] = pix.g; cat[5] = pix.b;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        lo_cnt_d  = lo_cnt_q;
        lo_sof_d  = lo_sof_q;
        err_d     = err_q;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        load_user = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (in_sof && (lo_cnt_q != 2'd0)) err_d = 1'b1;
                    if (eff_cnt == 2'd0) begin
                        if (in_eol) begin
                            load      = 1'b1;
                            load_data = pad_word({pix.b, pix.g, pix.r}, 2'd3, PAD_BYTE);
                            load_last = 1'b1;
                            load_user = in_sof;
                            lo_cnt_d  = 2'd0;
                            lo_sof_d  = 1'b0;
                        end else begin
                            lo_d[0]  = pix.r;
                            lo_d[1]  = pix.g;
                            lo_d[2]  = pix.b;
                            lo_cnt_d = 2'd3;
                            lo_sof_d = in_sof;
                        end
                    end else begin
                        // At least 4 bytes available: emit a full word, keep the tail.
                        load      = 1'b1;
                        load_data = {cat[3], cat[2], cat[1], cat[0]};
                        load_user = lo_sof_q;
                        lo_sof_d  = 1'b0;
                        lo_d[0]   = cat[4];
                        lo_d[1]   = cat[5];
                        lo_cnt_d  = eff_cnt - 2'd1;
                        if (in_eol) begin
                            if (eff_cnt == 2'd1) load_last = 1'b1;
                            else                 state_d   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = pad_word({lo_q[2], lo_q[1], lo_q[0]}, lo_cnt_q, PAD_BYTE);
                    load_last = 1'b1;
                    load_user = lo_sof_q;
                    lo_cnt_d  = 2'd0;
                    lo_sof_d  = 1'b0;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state_q  <= RUN;
            lo_cnt_q <= 2'd0;
            lo_sof_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 3; i++) lo_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            lo_cnt_q <= lo_cnt_d;
            lo_sof_q <= lo_sof_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
        end
    end

    pixel_packer_axis_out_reg #(.W(WORD_W)) u_out (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .load_user (load_user),
        .tready    (m_axis_tready),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast),
        .tuser     (m_axis_tuser)
    );

endmodule
